cordic_vectoring: RTL

CORDIC_VECTORING -- requirements
Module: cordic_vectoring

---
 rtl/cordic_vectoring.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC: converts a signed (x, y) sample into a magnitude
// and a micro-rotation direction code, one micro-rotation per clock.
// Define CORDIC_VECTORING_COMPENSATION_EN to add the two-cycle gain
// compensation stage (COMP). Without it, m_mag carries the raw CORDIC gain.
//
// state | meaning
// IDLE  | waiting for a sample, s_ready high
// ITER  | one micro-rotation per cycle, k = 0..ITERATIONS-1
// COMP  | gain compensation, two cycles (compensation builds only)
// DONE  | result presented, held until m_ready
module cordic_vectoring #(
  parameter int DATA_WIDTH = 16,
  parameter int ITERATIONS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_xin,
  input  logic [DATA_WIDTH-1:0] s_yin,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH+1:0] m_mag,
  output logic [ITERATIONS:0]   m_theta,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int DW = DATA_WIDTH + 2;
  localparam int KW = $clog2(ITERATIONS + 1);

`ifdef CORDIC_VECTORING_COMPENSATION_EN
  typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;
  logic cph;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t               state;
  logic [KW-1:0]        k;
  logic signed [DW-1:0] x, y;
  logic signed [DW-1:0] x_in, y_in, xs, ys, x_nx, y_nx;
  logic [ITERATIONS:0]  th, th_nx;
  logic                 last;

  // Accept only from IDLE and never while reset is held.
  assign s_ready = (state == IDLE) && !rst;

  // Sign extension, shifted operands and the next micro-rotation result.
  always_comb begin
    x_in  = {{2{s_xin[DATA_WIDTH-1]}}, s_xin};
    y_in  = {{2{s_yin[DATA_WIDTH-1]}}, s_yin};
    xs    = x >>> k;
    ys    = y >>> k;
    th_nx = th;
    if (y[DW-1]) begin
      x_nx = x - ys;
      y_nx = y + xs;
      th_nx[ITERATIONS-1-int'(k)] = 1'b0;
    end else begin
      x_nx = x + ys;
      y_nx = y - xs;
      th_nx[ITERATIONS-1-int'(k)] = 1'b1;
    end
    last = (k == KW'(ITERATIONS - 1));
  end

  // Sequencer and datapath registers, including the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      x       <= '0;
      y       <= '0;
      th      <= '0;
      m_mag   <= '0;
      m_theta <= '0;
      m_valid <= 1'b0;
`ifdef CORDIC_VECTORING_COMPENSATION_EN
      cph     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            // Fold the left half-plane onto the right; the pi is recorded in the top bit.
            if (x_in[DW-1]) begin
              x <= -x_in;
              y <= -y_in;
            end else begin
              x <= x_in;
              y <= y_in;
            end
            th             <= '0;
            th[ITERATIONS] <= x_in[DW-1];
            k              <= '0;
            state          <= ITER;
          end
        end
        ITER: begin
          x  <= x_nx;
          y  <= y_nx;
          th <= th_nx;
          if (last) begin
            k <= '0;
`ifdef CORDIC_VECTORING_COMPENSATION_EN
            cph   <= 1'b0;
            state <= COMP;
`else
            m_mag   <= x_nx;
            m_theta <= th_nx;
            m_valid <= 1'b1;
            state   <= DONE;
`endif
          end else begin
            k <= k + KW'(1);
          end
        end
`ifdef CORDIC_VECTORING_COMPENSATION_EN
        COMP: begin
          // 0.625 * (1 - 1/32) ~= 0.6055 approximates 1/K.
          if (!cph) begin
            x   <= (x >>> 1) + (x >>> 3);
            cph <= 1'b1;
          end else begin
            m_mag   <= x - (x >>> 5);
            m_theta <= th;
            m_valid <= 1'b1;
            cph     <= 1'b0;
            state   <= DONE;
          end
        end
`endif
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
